// File: rtl/riscy_mem_arbiter.sv
// riscy_mem_arbiter: shares one single-port memory between the fetch and data ports.
// Rev 1.0. Optional macro RISCY_ARB_ROUND_ROBIN_EN selects round-robin over data-first priority.
`default_nettype none

module riscy_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             instr_req_i,
    input  logic [31:0]      instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [31:0]      instr_rdata_o,
    input  logic             data_req_i,
    input  logic             data_we_i,
    input  logic [3:0]       data_be_i,
    input  logic [31:0]      data_addr_i,
    input  logic [31:0]      data_wdata_i,
    output logic             data_gnt_o,
    output logic             data_rvalid_o,
    output logic [31:0]      data_rdata_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [31:0]      mem_rdata_i,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             spurious_o
);

    localparam int               PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic             ID_INSTR = 1'b0;
    localparam logic             ID_DATA  = 1'b1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic                       sel_q, sel_d;
    logic                       en_q;
    logic [CNT_W-1:0]           count_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] id_fifo_q;
    logic                       winner, winner_req, active, push, pop, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

`ifdef RISCY_ARB_ROUND_ROBIN_EN
    logic last_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni)   last_q <= ID_INSTR;
        else if (push) last_q <= winner;
    end
`endif

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q    <= 1'b0;
            state_q <= IDLE;
            sel_q   <= ID_INSTR;
        end else begin
            en_q    <= 1'b1;
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;

        // A stalled address phase must not change under the memory's feet.
        if (state_q == LOCKED) begin
            winner = sel_q;
        end else if (instr_req_i && data_req_i) begin
`ifdef RISCY_ARB_ROUND_ROBIN_EN
            winner = ~last_q;
`else
            winner = ID_DATA;
`endif
        end else begin
            winner = data_req_i ? ID_DATA : ID_INSTR;
        end

        winner_req = (winner == ID_DATA) ? data_req_i : instr_req_i;
        active     = winner_req & en_q;
        mem_req_o  = active & (count_q < MAX_CNT);
        push       = mem_req_o & mem_gnt_i;

        if (active) begin
            if (winner == ID_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = 4'hF;
                mem_addr_o  = instr_addr_i;
            end
        end

        case (state_q)
            IDLE: begin
                if (mem_req_o && !mem_gnt_i) begin
                    state_d = LOCKED;
                    sel_d   = winner;
                end
            end
            LOCKED: begin
                if (push) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_gnt_o = push & (winner == ID_INSTR);
    assign data_gnt_o  = push & (winner == ID_DATA);

    assign pop            = mem_rvalid_i & en_q & (count_q != '0);
    assign head           = id_fifo_q[rd_ptr_q];
    assign instr_rvalid_o = pop & (head == ID_INSTR);
    assign data_rvalid_o  = pop & (head == ID_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign spurious_o     = mem_rvalid_i & (count_q == '0);
    assign outstanding_o  = count_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            id_fifo_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            if (push) begin
                id_fifo_q[wr_ptr_q] <= winner;
                wr_ptr_q            <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscy_mem_arbiter.sv
// tb_riscy_mem_arbiter: directed stimulus with a response scoreboard for riscy_mem_arbiter.
// Rev 1.0. Honours RISCY_ARB_ROUND_ROBIN_EN for contention expectations.
`default_nettype none

module tb_riscy_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [1:0]  outstanding_o;
    logic        spurious_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];
    logic [3:0]  cont_ids;

    riscy_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .outstanding_o(outstanding_o), .spurious_o(spurious_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
    endtask

    task automatic settle();
        #2;
    endtask

    // Memory returns a response; the routing the bench expects goes to the scoreboard.
    task automatic respond(input logic id, input logic [31:0] d);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        exp_q.push_back({id, d});
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (instr_rvalid_o || data_rvalid_o) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_route: got instr_rvalid=%0b data_rvalid=%0b, expected no response",
                         instr_rvalid_o, data_rvalid_o);
            end else begin
                e = exp_q.pop_front();
                if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o} !==
                    {~e[32], e[32], e[31:0], e[31:0]}) begin
                    n_bad++;
                    $display("FAIL rsp_route: got iv=%0b dv=%0b ird=0x%0h drd=0x%0h expected iv=%0b dv=%0b rd=0x%0h",
                             instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o,
                             ~e[32], e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef RISCY_ARB_ROUND_ROBIN_EN
        cont_ids = 4'b0101;
`else
        cont_ids = 4'b1111;
`endif
        rst_ni = 1'b0;
        instr_req_i = 1'b0; instr_addr_i = 32'h0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i = 32'h0; data_wdata_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

        // Reset state
        tick(); settle();
        chk("rst_mem_req", 32'(mem_req_o), 32'h0);
        chk("rst_mem_be", 32'(mem_be_o), 32'h0);
        chk("rst_outstanding", 32'(outstanding_o), 32'h0);
        chk("rst_spurious", 32'(spurious_o), 32'h0);
        chk("rst_gnts", 32'({instr_gnt_o, data_gnt_o}), 32'h0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Single fetch
        instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
        settle();
        chk("fetch_mem_req", 32'(mem_req_o), 32'h1);
        chk("fetch_mem_addr", mem_addr_o, 32'h100);
        chk("fetch_mem_be_we", 32'({mem_be_o, mem_we_o}), 32'h1E);
        chk("fetch_gnts", 32'({instr_gnt_o, data_gnt_o}), 32'h2);
        tick();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0;
        respond(1'b0, 32'hDEADBEEF);
        settle();
        chk("fetch_outstanding1", 32'(outstanding_o), 32'h1);
        chk("fetch_spurious", 32'(spurious_o), 32'h0);
        tick(); settle();
        chk("fetch_outstanding0", 32'(outstanding_o), 32'h0);

        // Contention: both request every cycle
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h200;
        data_req_i = 1'b1; data_addr_i = 32'h300; data_we_i = 1'b0; data_be_i = 4'hF;
        mem_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) respond(cont_ids[k-1], 32'hA0000000 + 32'(k - 1));
            settle();
            chk("cont_mem_addr", mem_addr_o, cont_ids[k] ? 32'h300 : 32'h200);
            chk("cont_gnts", 32'({instr_gnt_o, data_gnt_o}), cont_ids[k] ? 32'h1 : 32'h2);
            tick();
        end
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0;
        respond(cont_ids[3], 32'hA0000003);
        tick(); settle();
        chk("cont_outstanding0", 32'(outstanding_o), 32'h0);

        // Stall lock: instr stalled, then data arrives and must wait
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h500;
        settle();
        chk("lock_i_addr0", mem_addr_o, 32'h500);
        tick();
        data_req_i = 1'b1; data_addr_i = 32'h400; data_we_i = 1'b1;
        data_be_i = 4'h3; data_wdata_i = 32'h12345678;
        settle();
        chk("lock_i_addr1", mem_addr_o, 32'h500);
        chk("lock_i_we", 32'(mem_we_o), 32'h0);
        tick();
        mem_gnt_i = 1'b1;
        settle();
        chk("lock_i_gnts", 32'({instr_gnt_o, data_gnt_o}), 32'h2);
        tick();
        // Data stalled for three cycles; instr requests in the middle
        instr_req_i = 1'b0; mem_gnt_i = 1'b0;
        respond(1'b0, 32'h55555555);
        settle();
        chk("lock_d_bus", {mem_addr_o[15:0], 8'(mem_be_o), 7'h0, mem_we_o}, 32'h04000301);
        chk("lock_d_wdata", mem_wdata_o, 32'h12345678);
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h504;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("lock_d_addr", mem_addr_o, 32'h400);
            chk("lock_d_no_igrant", 32'(instr_gnt_o), 32'h0);
            tick();
        end
        mem_gnt_i = 1'b1;
        settle();
        chk("lock_d_gnts", 32'({instr_gnt_o, data_gnt_o}), 32'h1);
        tick();
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; data_we_i = 1'b0;
        respond(1'b1, 32'h0000CAFE);
        tick(); settle();
        chk("lock_outstanding0", 32'(outstanding_o), 32'h0);

        // Full: two grants, no responses
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h600; mem_gnt_i = 1'b1;
        tick();
        instr_req_i = 1'b0;
        data_req_i = 1'b1; data_addr_i = 32'h700; data_be_i = 4'hF;
        tick();
        data_req_i = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'h608;
        respond(1'b0, 32'h00006000);
        settle();
        chk("full_outstanding2", 32'(outstanding_o), 32'h2);
        chk("full_mem_req", 32'(mem_req_o), 32'h0);
        chk("full_igrant", 32'(instr_gnt_o), 32'h0);
        tick();
        respond(1'b1, 32'h00007000);
        settle();
        chk("full_req_back", 32'(mem_req_o), 32'h1);
        chk("full_igrant_back", 32'(instr_gnt_o), 32'h1);
        chk("full_addr_back", mem_addr_o, 32'h608);
        tick();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0;
        respond(1'b0, 32'h00006080);
        tick(); settle();
        chk("full_outstanding0", 32'(outstanding_o), 32'h0);

        // Spurious response with empty FIFO
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
        settle();
        chk("spur_pulse", 32'(spurious_o), 32'h1);
        chk("spur_no_rvalid", 32'({instr_rvalid_o, data_rvalid_o}), 32'h0);
        tick(); settle();
        chk("spur_clear", 32'(spurious_o), 32'h0);
        chk("spur_outstanding", 32'(outstanding_o), 32'h0);

        // Reset with two outstanding
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h800; mem_gnt_i = 1'b1;
        tick();
        instr_addr_i = 32'h804;
        tick();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0;
        settle();
        chk("mid_outstanding2", 32'(outstanding_o), 32'h2);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_outstanding", 32'(outstanding_o), 32'h0);
        instr_req_i = 1'b1; mem_gnt_i = 1'b1;
        settle();
        chk("mid_rst_mem_req", 32'(mem_req_o), 32'h0);
        tick();
        rst_ni = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00000800;
        settle();
        chk("post_rst_spurious", 32'(spurious_o), 32'h1);
        chk("post_rst_no_gnt", 32'({mem_req_o, instr_gnt_o}), 32'h0);
        tick();
        settle();
        chk("post_rst_gnt", 32'(instr_gnt_o), 32'h1);
        chk("post_rst_no_spur", 32'(spurious_o), 32'h0);
        tick();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0;
        respond(1'b0, 32'h99999999);
        tick(); settle();
        chk("end_outstanding0", 32'(outstanding_o), 32'h0);
        chk("end_scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/riscy_mem_arbiter.md
# riscy_mem_arbiter

Shares one single-port memory between the RISCY core's instruction-fetch and data-access ports, using the req/gnt/rvalid handshake on all three sides. Sits between the core and the bench memory model or SRAM. It arbitrates address phases, keeps a granted-but-stalled choice stable, and routes each in-order response back to its requester through an ID FIFO.

## Interface
Parameters:
- MAX_OUTSTANDING, 2: maximum accepted address phases awaiting rvalid (1..8).
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of the outstanding counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  fetch address.
- instr_gnt_o  out  1  fetch address phase accepted.
- instr_rvalid_o  out  1  fetch data valid.
- instr_rdata_o  out  32  fetch data.
- data_req_i  in  1  data request.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  data address.
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  data address phase accepted.
- data_rvalid_o  out  1  data response valid (reads and writes).
- data_rdata_o  out  32  read data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_be_o  out  4  memory byte enables.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_gnt_i  in  1  memory accepted address phase.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  32  memory read data.
- outstanding_o  out  CNT_W  current FIFO occupancy.
- spurious_o  out  1  one-cycle pulse on mem_rvalid_i with an empty FIFO.

## Operation
- `en_q` register: cleared by reset, set on the first clk edge after rst_ni rises. While `en_q` = 0, all req/gnt/rvalid outputs are 0.
- States: IDLE (no lock) and LOCKED (`sel_q` holds the winner). On a cycle with mem_req_o = 1 and mem_gnt_i = 0, the block enters LOCKED. In LOCKED, the mux stays on `sel_q` regardless of the other requester. The block returns to IDLE on the cycle mem_gnt_i = 1.
- Arbitration happens in IDLE only.
  - Single requester wins.
  - Both requesting: the policy is set by Configuration.
- Mux is combinational to the mem_* outputs from the winner.
  - Instruction winner: mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0.
  - mem_req_o = winner_req & en_q & (count < MAX_OUTSTANDING).
- winner gnt_o = mem_gnt_i & mem_req_o. The loser's gnt_o = 0.
- Handshake: on mem_req_o & mem_gnt_i, the winner ID (0 = instr, 1 = data) is pushed into the FIFO.
- Response: on mem_rvalid_i with count > 0, the head is popped.
  - The head's rvalid_o is driven to 1 and the other requester's is driven to 0.
  - mem_rdata_i is passed to both rdata outputs unconditionally.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- Full (count = MAX_OUTSTANDING): mem_req_o = 0, even if a pop occurs the same cycle. Lock state is held.
- Empty with mem_rvalid_i: no rvalid_o. spurious_o = 1 for that cycle and count stays 0.

## Timing
- Address phase: zero-cycle combinational path from req_i to mem_req_o and from mem_gnt_i to gnt_o.
- Response: zero-cycle combinational path from mem_rvalid_i to rvalid_o. Memory must not assert rvalid in the same cycle as the corresponding gnt.
- FIFO, counter, `sel_q`, lock and `en_q` are registered.
- Reset values: count = 0, pointers = 0, IDLE, `sel_q` = instr, RR last-granted = instr. All outputs read 0 (mux idle, spurious_o = 0).
- Reset mid-transaction: outstanding IDs are discarded. Later mem_rvalid_i pulses raise spurious_o and are not forwarded.

## Configuration
- `RISCY_ARB_ROUND_ROBIN_EN` defined: round-robin. On contention, the requester not granted most recently wins. The last-granted register updates on each handshake.
- Undefined: fixed priority, data over instr. The last-granted register is not built.

## Test plan
- Single fetch: instr_req_i = 1 at 0x100, mem_gnt_i = 1 same cycle, mem_rvalid_i next cycle with 0xDEADBEEF -> instr_gnt_o pulse, instr_rvalid_o = 1, instr_rdata_o = 0xDEADBEEF, data_rvalid_o = 0, outstanding_o returns to 0.
- Contention: both request every cycle, mem_gnt_i = 1 -> RR build alternates data, instr, data, …; fixed build grants only data while data_req_i = 1.
- Stall lock: data wins with mem_gnt_i = 0 for 3 cycles, instr then requests -> mem_addr_o stays at the data address, instr_gnt_o = 0 until the data gnt.
- Full: MAX_OUTSTANDING = 2, two grants with no rvalid -> outstanding_o = 2, mem_req_o = 0; after one rvalid -> mem_req_o reasserts the next cycle; responses route in grant order.
- Spurious/reset: mem_rvalid_i with empty FIFO -> spurious_o one-cycle pulse; rst_ni low with 2 outstanding -> outstanding_o = 0, following rvalids flagged spurious, no gnt until one cycle after release.
